// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared source IDs, default widths, writeback entry type and
// the round-robin pick helper for the register writeback unit.
package reg_wb_pkg;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 36;
    localparam int unsigned DEFAULT_NUM_REGS      = 4;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = $clog2(DEFAULT_NUM_REGS);

    typedef struct packed {
        logic [DEFAULT_ADDRESS_WIDTH-1:0] rd;
        logic [DEFAULT_DATA_WIDTH-1:0]    data;
    } wb_entry_t;

    // Tie goes to the source that did not win last; otherwise the lone
    // non-empty source. Result is meaningless when both are empty.
    function automatic src_e rr_pick(input logic alu_ne, input logic mem_ne, input src_e last);
        if (alu_ne && mem_ne) begin
            return (last == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end else if (mem_ne) begin
            return SRC_MEM;
        end
        return SRC_ALU;
    endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: count-based synchronous FIFO, power-of-two depth, no push-through
// (a pushed entry reaches the head only after the push edge).
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_empty = (count == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: buffers ALU and load results in per-source FIFOs and issues
// at most one registered register-file write per cycle, round-robin.
// Optional scoreboard (busy bits + issue ports) under REG_WB_SCOREBOARD_EN.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int unsigned NUM_REGS      = DEFAULT_NUM_REGS,
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = $clog2(NUM_REGS),
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_alu_rd,
    input  logic [DATA_WIDTH-1:0]    i_alu_data,
    output logic                     o_alu_ready,
    input  logic                     i_mem_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_mem_rd,
    input  logic [DATA_WIDTH-1:0]    i_mem_data,
    output logic                     o_mem_ready,
`ifdef REG_WB_SCOREBOARD_EN
    input  logic                     i_issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_issue_rd,
    output logic [NUM_REGS-1:0]      o_busy,
`endif
    output logic                     o_rf_wen,
    output logic [ADDRESS_WIDTH-1:0] o_rf_rd,
    output logic [DATA_WIDTH-1:0]    o_rf_wdata
);

    localparam int unsigned ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } entry_t;

    entry_t alu_in, mem_in, alu_head, mem_head, win;
    logic   alu_full, alu_empty, mem_full, mem_empty;
    logic   alu_push, mem_push, alu_pop, mem_pop, gnt_valid;
    src_e   last_grant, gnt_src;

    assign o_alu_ready = !alu_full;
    assign o_mem_ready = !mem_full;
    assign alu_push    = i_alu_valid && o_alu_ready;
    assign mem_push    = i_mem_valid && o_mem_ready;
    assign alu_in      = '{rd: i_alu_rd, data: i_alu_data};
    assign mem_in      = '{rd: i_mem_rd, data: i_mem_data};

    wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (alu_push),
        .i_data  (alu_in),
        .i_pop   (alu_pop),
        .o_data  (alu_head),
        .o_full  (alu_full),
        .o_empty (alu_empty)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_mem_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (mem_push),
        .i_data  (mem_in),
        .i_pop   (mem_pop),
        .o_data  (mem_head),
        .o_full  (mem_full),
        .o_empty (mem_empty)
    );

    // Round-robin grant over the two FIFO heads.
    always_comb begin
        gnt_valid = !alu_empty || !mem_empty;
        gnt_src   = rr_pick(!alu_empty, !mem_empty, last_grant);
        alu_pop   = gnt_valid && (gnt_src == SRC_ALU);
        mem_pop   = gnt_valid && (gnt_src == SRC_MEM);
        win       = (gnt_src == SRC_MEM) ? mem_head : alu_head;
    end

    // Registered write port; rd/wdata hold when nothing is granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= SRC_MEM;
            o_rf_wen   <= 1'b0;
            o_rf_rd    <= '0;
            o_rf_wdata <= '0;
        end else begin
            o_rf_wen <= gnt_valid;
            if (gnt_valid) begin
                last_grant <= gnt_src;
                o_rf_rd    <= win.rd;
                o_rf_wdata <= win.data;
            end
        end
    end

`ifdef REG_WB_SCOREBOARD_EN
    // Busy bits: clear on commit, set on issue; the later set wins a collision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy <= '0;
        end else begin
            if (o_rf_wen)      o_busy[o_rf_rd]    <= 1'b0;
            if (i_issue_valid) o_busy[i_issue_rd] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed vector table plus hand-written multi-cycle
// sequences for the reg_writeback unit (default parameters).
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_v, mem_v, alu_rdy, mem_rdy;
    logic [1:0]  alu_rd, mem_rd;
    logic [35:0] alu_d, mem_d;
    logic        wen;
    logic [1:0]  wrd;
    logic [35:0] wdata;
`ifdef REG_WB_SCOREBOARD_EN
    logic        iss_v;
    logic [1:0]  iss_rd;
    logic [3:0]  busy;
`endif

    int total = 0;
    int bad   = 0;

    logic [35:0] exp_a[$];
    logic [35:0] exp_m[$];
    logic [1:0]  log_rd[$];
    logic [35:0] log_d[$];

    always #5 clk = ~clk;

    reg_writeback #(
        .NUM_REGS      (4),
        .DATA_WIDTH    (36),
        .ADDRESS_WIDTH (2),
        .FIFO_DEPTH    (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_alu_valid   (alu_v),
        .i_alu_rd      (alu_rd),
        .i_alu_data    (alu_d),
        .o_alu_ready   (alu_rdy),
        .i_mem_valid   (mem_v),
        .i_mem_rd      (mem_rd),
        .i_mem_data    (mem_d),
        .o_mem_ready   (mem_rdy),
`ifdef REG_WB_SCOREBOARD_EN
        .i_issue_valid (iss_v),
        .i_issue_rd    (iss_rd),
        .o_busy        (busy),
`endif
        .o_rf_wen      (wen),
        .o_rf_rd       (wrd),
        .o_rf_wdata    (wdata)
    );

    typedef struct {
        logic        av;
        logic [1:0]  ard;
        logic [35:0] ad;
        logic        mv;
        logic [1:0]  mrd;
        logic [35:0] md;
        logic        ewen;
        logic [1:0]  erd;
        logic [35:0] edata;
        logic        eardy;
        logic        emrdy;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Both sources offer n items each (ALU rd=1, MEM rd=2), valid held until accepted.
    task automatic stream(input string tag, input int n, input logic [35:0] abase,
                          input logic [35:0] mbase, output logic bp_a, output logic bp_m);
        int ai = 0;
        int mi = 0;
        int cyc = 0;
        logic acc_a, acc_m;
        bp_a = 1'b0;
        bp_m = 1'b0;
        while ((ai < n || mi < n) && cyc < 60) begin
            alu_v  = (ai < n);
            alu_rd = 2'd1;
            alu_d  = abase + 36'(ai);
            mem_v  = (mi < n);
            mem_rd = 2'd2;
            mem_d  = mbase + 36'(mi);
            acc_a  = alu_v && alu_rdy;
            acc_m  = mem_v && mem_rdy;
            if (alu_v && !alu_rdy) bp_a = 1'b1;
            if (mem_v && !mem_rdy) bp_m = 1'b1;
            tick();
            if (acc_a) begin exp_a.push_back(alu_d); ai++; end
            if (acc_m) begin exp_m.push_back(mem_d); mi++; end
            if (wen) begin log_rd.push_back(wrd); log_d.push_back(wdata); end
            cyc++;
        end
        alu_v = 1'b0;
        mem_v = 1'b0;
        check({tag, " accepted"}, 64'(ai + mi), 64'(2 * n));
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wen) begin log_rd.push_back(wrd); log_d.push_back(wdata); end
        end
    endtask

    initial begin
        logic        bp_a, bp_m;
        logic [1:0]  c_rd[6];
        logic [35:0] c_d[6];
        logic [35:0] e;

        vt[0] = '{1'b1, 2'd2, 36'h0_1234_5678, 1'b0, 2'd0, 36'h0, 1'b0, 2'd0, 36'h0,           1'b1, 1'b1};
        vt[1] = '{1'b0, 2'd0, 36'h0,           1'b0, 2'd0, 36'h0, 1'b1, 2'd2, 36'h0_1234_5678, 1'b1, 1'b1};
        vt[2] = '{1'b0, 2'd0, 36'h0,           1'b0, 2'd0, 36'h0, 1'b0, 2'd2, 36'h0_1234_5678, 1'b1, 1'b1};
        vt[3] = '{1'b0, 2'd0, 36'h0,           1'b1, 2'd1, 36'hA, 1'b0, 2'd2, 36'h0_1234_5678, 1'b1, 1'b1};
        vt[4] = '{1'b1, 2'd3, 36'hB,           1'b1, 2'd0, 36'hC, 1'b1, 2'd1, 36'hA,           1'b1, 1'b1};
        vt[5] = '{1'b0, 2'd0, 36'h0,           1'b0, 2'd0, 36'h0, 1'b1, 2'd3, 36'hB,           1'b1, 1'b1};
        vt[6] = '{1'b0, 2'd0, 36'h0,           1'b0, 2'd0, 36'h0, 1'b1, 2'd0, 36'hC,           1'b1, 1'b1};
        vt[7] = '{1'b0, 2'd0, 36'h0,           1'b0, 2'd0, 36'h0, 1'b0, 2'd0, 36'hC,           1'b1, 1'b1};

        c_rd[0] = 2'd1; c_d[0] = 36'h1;
        c_rd[1] = 2'd2; c_d[1] = 36'h11;
        c_rd[2] = 2'd1; c_d[2] = 36'h2;
        c_rd[3] = 2'd2; c_d[3] = 36'h12;
        c_rd[4] = 2'd1; c_d[4] = 36'h3;
        c_rd[5] = 2'd2; c_d[5] = 36'h13;

        alu_v = 1'b0; alu_rd = '0; alu_d = '0;
        mem_v = 1'b0; mem_rd = '0; mem_d = '0;
`ifdef REG_WB_SCOREBOARD_EN
        iss_v = 1'b0; iss_rd = '0;
`endif
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset wen", 64'(wen), 64'd0);
        check("reset rd", 64'(wrd), 64'd0);
        check("reset wdata", 64'(wdata), 64'd0);
        check("reset alu_ready", 64'(alu_rdy), 64'd1);
        check("reset mem_ready", 64'(mem_rdy), 64'd1);
`ifdef REG_WB_SCOREBOARD_EN
        check("reset busy", 64'(busy), 64'd0);
`endif
        #3 rst_n = 1'b1;

        // Directed vector table: single write, hold, simple arbitration
        for (int i = 0; i < 8; i++) begin
            alu_v = vt[i].av; alu_rd = vt[i].ard; alu_d = vt[i].ad;
            mem_v = vt[i].mv; mem_rd = vt[i].mrd; mem_d = vt[i].md;
            tick();
            check($sformatf("vec%0d wen", i), 64'(wen), 64'(vt[i].ewen));
            check($sformatf("vec%0d rd", i), 64'(wrd), 64'(vt[i].erd));
            check($sformatf("vec%0d wdata", i), 64'(wdata), 64'(vt[i].edata));
            check($sformatf("vec%0d alu_ready", i), 64'(alu_rdy), 64'(vt[i].eardy));
            check($sformatf("vec%0d mem_ready", i), 64'(mem_rdy), 64'(vt[i].emrdy));
        end
        alu_v = 1'b0; mem_v = 1'b0;

        // Contention: strict alternation starting with ALU
        stream("contention", 3, 36'h1, 36'h11, bp_a, bp_m);
        check("contention write count", 64'(log_d.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_d.size()) begin
                check($sformatf("contention w%0d rd", i), 64'(log_rd[i]), 64'(c_rd[i]));
                check($sformatf("contention w%0d data", i), 64'(log_d[i]), 64'(c_d[i]));
            end
        end
        exp_a.delete(); exp_m.delete(); log_rd.delete(); log_d.delete();

        // Backpressure: readies must drop, every accepted entry written once in order
        stream("backpressure", 8, 36'h100, 36'h200, bp_a, bp_m);
        check("bp alu_ready dropped", 64'(bp_a), 64'd1);
        check("bp mem_ready dropped", 64'(bp_m), 64'd1);
        check("bp write count", 64'(log_d.size()), 64'd16);
        for (int i = 0; i < log_d.size(); i++) begin
            if (log_rd[i] == 2'd1 && exp_a.size() > 0) begin
                e = exp_a.pop_front();
                check($sformatf("bp alu w%0d", i), 64'(log_d[i]), 64'(e));
            end else if (log_rd[i] == 2'd2 && exp_m.size() > 0) begin
                e = exp_m.pop_front();
                check($sformatf("bp mem w%0d", i), 64'(log_d[i]), 64'(e));
            end else begin
                check($sformatf("bp unexpected w%0d rd", i), 64'(log_rd[i]), 64'hFFFF);
            end
        end
        check("bp alu leftovers", 64'(exp_a.size()), 64'd0);
        check("bp mem leftovers", 64'(exp_m.size()), 64'd0);
        log_rd.delete(); log_d.delete();

`ifdef REG_WB_SCOREBOARD_EN
        // Scoreboard: set on issue, clear on commit edge, set wins collision
        iss_v = 1'b1; iss_rd = 2'd3;
        tick();
        iss_v = 1'b0;
        check("sb busy after issue", 64'(busy), 64'h8);
        mem_v = 1'b1; mem_rd = 2'd3; mem_d = 36'h33;
        tick();
        mem_v = 1'b0;
        check("sb busy after accept", 64'(busy), 64'h8);
        tick();
        check("sb wen", 64'(wen), 64'd1);
        check("sb busy while wen", 64'(busy), 64'h8);
        tick();
        check("sb busy cleared", 64'(busy), 64'h0);
        iss_v = 1'b1; iss_rd = 2'd3;
        tick();
        iss_v = 1'b0;
        mem_v = 1'b1; mem_rd = 2'd3; mem_d = 36'h34;
        tick();
        mem_v = 1'b0;
        tick();
        check("sb wen 2", 64'(wen), 64'd1);
        iss_v = 1'b1; iss_rd = 2'd3;
        tick();
        iss_v = 1'b0;
        check("sb set wins", 64'(busy), 64'h8);
`endif

        // Reset mid-stream with both FIFOs holding entries
        alu_v = 1'b1; alu_rd = 2'd3; alu_d = 36'h55;
        mem_v = 1'b1; mem_rd = 2'd2; mem_d = 36'h66;
        tick();
        alu_rd = 2'd1; alu_d = 36'h77;
        mem_v = 1'b0;
        tick();
        alu_v = 1'b0;
        check("pre-reset wen", 64'(wen), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset wen", 64'(wen), 64'd0);
        check("async reset rd", 64'(wrd), 64'd0);
        check("async reset wdata", 64'(wdata), 64'd0);
        check("async reset alu_ready", 64'(alu_rdy), 64'd1);
        check("async reset mem_ready", 64'(mem_rdy), 64'd1);
`ifdef REG_WB_SCOREBOARD_EN
        check("async reset busy", 64'(busy), 64'd0);
`endif
        tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("post-reset idle%0d wen", i), 64'(wen), 64'd0);
        end
        alu_v = 1'b1; alu_rd = 2'd2; alu_d = 36'h99;
        tick();
        alu_v = 1'b0;
        check("post-reset accept wen", 64'(wen), 64'd0);
        tick();
        check("post-reset write wen", 64'(wen), 64'd1);
        check("post-reset write rd", 64'(wrd), 64'd2);
        check("post-reset write data", 64'(wdata), 64'h99);
        tick();
        check("post-reset single pulse", 64'(wen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback unit that drives the register file's write port (`rd`, `wdata`, `wen`). It takes results from two producers, the ALU and the memory load path, over independent valid/ready handshakes. Each result is buffered in a small per-source FIFO, and a round-robin arbiter issues at most one register write per cycle. An optional scoreboard tracks registers with writes in flight so that decode can stall on hazards.

## Interface

Parameters:
- `NUM_REGS`, 4: number of architectural registers.
- `DATA_WIDTH`, 36: register width.
- `ADDRESS_WIDTH`, `$clog2(NUM_REGS)`: register index width.
- `FIFO_DEPTH`, 2: entries per source FIFO; must be a power of two, ≥2.

Ports:
- `i_clk`, in, 1: clock. One clock domain; everything is sampled on the rising edge.
- `i_rst_n`, in, 1: reset. Asynchronous, active-low.
- `i_alu_valid`, in, 1: ALU result valid.
- `i_alu_rd`, in, `ADDRESS_WIDTH`: ALU destination register.
- `i_alu_data`, in, `DATA_WIDTH`: ALU result.
- `o_alu_ready`, out, 1: ALU FIFO can accept.
- `i_mem_valid`, in, 1: load result valid.
- `i_mem_rd`, in, `ADDRESS_WIDTH`: load destination register.
- `i_mem_data`, in, `DATA_WIDTH`: load data.
- `o_mem_ready`, out, 1: MEM FIFO can accept.
- `o_rf_wen`, out, 1: register file write enable (registered).
- `o_rf_rd`, out, `ADDRESS_WIDTH`: register file destination (registered).
- `o_rf_wdata`, out, `DATA_WIDTH`: register file write data (registered).
- `i_issue_valid`, in, 1: an instruction with a destination is issued. Present only with `REG_WB_SCOREBOARD_EN`.
- `i_issue_rd`, in, `ADDRESS_WIDTH`: the issued destination register. Present only with `REG_WB_SCOREBOARD_EN`.
- `o_busy`, out, `NUM_REGS`: per-register pending-write bits. Present only with `REG_WB_SCOREBOARD_EN`.

## Operation

- **Handshake:** a transfer occurs when `valid && ready` at a clock edge.
  - `ready` = FIFO count < `FIFO_DEPTH`, driven from registered state only.
  - `valid`, `rd` and `data` must stay stable while `valid && !ready`.
- **FIFOs:** one per source, in-order.
  - No push-through: an entry pushed at edge k is first visible at the head after edge k.
  - When full, there is no simultaneous push and pop, because `ready` is already low.
- **Arbiter:** combinational over the two FIFO heads, with a 1-bit `last_grant` register.
  - Only one head non-empty: grant it.
  - Both non-empty: grant the source that is not `last_grant`.
  - `last_grant` updates on every grant.
  - At reset `last_grant` = MEM, so the ALU wins the first tie.
- **Output register:**
  - On a grant: the head entry is popped, and after the same edge `o_rf_wen`=1 with the entry's `o_rf_rd`/`o_rf_wdata`.
  - No grant: `o_rf_wen`=0, and `o_rf_rd`/`o_rf_wdata` hold their last values.
- **Ordering:** order between sources is arbitration order, not program order. Preventing same-`rd` races is the producers' and scoreboard's job.
- **Scoreboard** (when compiled in):
  - `o_busy[i_issue_rd]` sets on an edge with `i_issue_valid`.
  - `o_busy[o_rf_rd]` clears on an edge where `o_rf_wen`=1, i.e. the same edge the register file commits.
  - Set and clear of the same register on the same edge: set wins.
  - Issuing to an already-busy register keeps it busy; there is no counting.
- **Reset values:** `o_rf_wen`=0, `o_rf_rd`=0, `o_rf_wdata`=0, `o_busy`=0, both readies=1, FIFOs empty.

## Timing

- Latency from acceptance at edge k:
  - Entry is at the FIFO head after edge k.
  - `o_rf_wen` is high after edge k+1.
  - The register file write lands at edge k+2.
- Throughput: one register write per cycle in aggregate.
  - A single source alone sustains 1 per cycle.
  - Under contention each source gets 1 per 2 cycles.
- Asynchronous reset at any time:
  - Outputs go to reset values immediately.
  - Buffered results are discarded.
  - No write is issued after `i_rst_n` deasserts until new data is accepted.

## Configuration

- `REG_WB_SCOREBOARD_EN` defined: the `i_issue_valid`, `i_issue_rd` and `o_busy` ports and the busy register are present, with the behaviour described above.
- `REG_WB_SCOREBOARD_EN` undefined: those ports and that logic are absent. The writeback datapath is cycle-identical to the defined case.

## Structure

- Package `reg_wb_pkg` holds:
  - source ID constants `SRC_ALU`=0 and `SRC_MEM`=1;
  - default width constants (36 data, 4 registers);
  - the entry typedef {rd, data}.
- Sub-module `wb_fifo`: a parameterised synchronous FIFO (depth, width, count-based full/empty) with asynchronous active-low reset, instantiated once per source.

## Test plan

- **Reset:** hold `i_rst_n`=0 → `o_rf_wen`=0, `o_rf_rd`=0, `o_rf_wdata`=0, `o_busy`=4'b0000, `o_alu_ready`=`o_mem_ready`=1.
- **Single ALU write:** ALU rd=2, data=36'h0_1234_5678, accepted at edge k → `o_rf_wen`=1, rd=2, data=36'h0_1234_5678 for exactly one cycle after edge k+1.
- **Contention:** both sources continuously valid, ALU data 1,2,3 and MEM data 0x11,0x12,0x13 → writes in the order 1,0x11,2,0x12,3,0x13.
- **Backpressure:** both sources valid every cycle for 8 cycles with FIFO_DEPTH=2 → each ready drops once its FIFO is full. All accepted entries are written exactly once, in per-source order, with none lost or duplicated.
- **Scoreboard:**
  - Issue rd=3 → `o_busy[3]`=1 after the edge.
  - MEM write to rd=3 → `o_busy[3]` clears at the edge where `o_rf_wen`=1.
  - Issue rd=3 on that same edge → `o_busy[3]` stays 1.
- **Reset mid-stream:** pull `i_rst_n` low with both FIFOs non-empty → outputs go to reset values without waiting for a clock edge. After release, no `o_rf_wen` pulse occurs until a new handshake.
